ahb_slv_sram: RTL

AHB slave (responder) exposing a word-organised on-chip SRAM to a single AHB master. It is the far end of the master-side bus port. It decodes address-phase controls, inserts a configurable number of wait states, and performs byte/halfword/word reads and writes. Illegal accesses receive the two-cycle ERROR response. It sits directly on the bus as the only slave, so its hready output is the bus hready.

---
 rtl/ahb_pkg.sv | 60 ++++++
 rtl/ahb_sram_bank.sv | 29 ++
 rtl/ahb_slv_sram.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings, slave FSM states and lane helpers
// shared by the ahb_slv_sram block and its SRAM bank.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } slv_state_e;

   // Size/alignment legality; address range is checked by the caller.
   function automatic logic size_ok(
      input logic [2:0] size,
      input logic [1:0] lane
   );
      logic ok;
      ok = 1'b0;
      case (size)
         HSIZE_BYTE: ok = 1'b1;
         HSIZE_HALF: ok = ~lane[0];
         HSIZE_WORD: ok = (lane == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Little-endian byte enables for a legal transfer.
   function automatic logic [3:0] byte_en(
      input logic [2:0] size,
      input logic [1:0] lane
   );
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lane;
         HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// ahb_sram_bank: DEPTH x 32 storage, byte-enable synchronous write,
// combinational read. Contents are deliberately not reset.
module ahb_sram_bank #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slv_sram.sv
// ahb_slv_sram: single-slave AHB responder in front of an on-chip SRAM
// with configurable wait states and two-cycle ERROR responses.
module ahb_slv_sram #(
   parameter int A_WIDTH     = 32,
   parameter int D_WIDTH     = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic               hclk,
   input  logic               hreset_n,
   input  logic               hsel,
   input  logic [A_WIDTH-1:0] haddr,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [2:0]         hburst,
   input  logic [3:0]         hprot,
   input  logic [1:0]         htrans,
   input  logic               hmstrlock,
   input  logic [D_WIDTH-1:0] hwdata,
   output logic               hready,
   output logic               hresp,
   output logic [D_WIDTH-1:0] hrdata
);

   import ahb_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD =
      4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   slv_state_e    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          write_q, write_d;
   logic [2:0]    size_q, size_d;
   logic [1:0]    lane_q, lane_d;
   logic [AW-1:0] widx_q, widx_d;

   logic          accept;
   logic          in_range;
   logic          legal;
   logic          complete;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_rdata;
   logic          unused_ok;

   assign unused_ok = ^{hburst, hprot, hmstrlock};

   assign accept = hready & hsel &
                   ((htrans == HTRANS_NONSEQ) ||
                    (htrans == HTRANS_SEQ));

   assign in_range = ((haddr >> (AW + 2)) == '0);
   assign legal    = in_range & size_ok(hsize, haddr[1:0]);

   // Only IDLE with a pending legal beat is a completing data cycle.
   assign complete = pend_q & (state_q == ST_IDLE);
   assign mem_we   = complete & write_q;
   assign mem_be   = byte_en(size_q, lane_q);
   assign hrdata   = (complete & ~write_q) ? mem_rdata : '0;

   always_comb begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      unique case (state_q)
         ST_WAIT: hready = 1'b0;
         ST_ERR1: begin
            hready = 1'b0;
            hresp  = HRESP_ERROR;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      write_d = write_q;
      size_d  = size_q;
      lane_d  = lane_q;
      widx_d  = widx_q;
      unique case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // IDLE and ERR2 both evaluate a new address phase.
            pend_d  = 1'b0;
            state_d = ST_IDLE;
            if (accept) begin
               write_d = hwrite;
               size_d  = hsize;
               lane_d  = haddr[1:0];
               widx_d  = haddr[AW+1:2];
               if (!legal) begin
                  state_d = ST_ERR1;
               end else begin
                  pend_d = 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_d = ST_WAIT;
                     cnt_d   = WS_LOAD;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         lane_q  <= 2'd0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         write_q <= write_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         widx_q  <= widx_d;
      end
   end

   ahb_sram_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk_i   (hclk),
      .we_i    (mem_we),
      .be_i    (mem_be),
      .addr_i  (widx_q),
      .wdata_i (hwdata),
      .rdata_o (mem_rdata)
   );

endmodule
